// File: rtl/user_proj_solar_mc_pkg.sv
// -----------------------------------------------------------------------------
// solar_pkg
// Shared types and constants for the multi-channel solar monitor.
//   track_e      : sun-tracking direction / FSM state encoding
//   FAULT_CNT_W  : width of the per-channel fault debounce counter (holds 0..255)
//   TRACK_W      : width of the tracking direction output
// -----------------------------------------------------------------------------
package solar_pkg;

    typedef enum logic [1:0] {
        TRACK_HOLD = 2'b00,
        TRACK_EAST = 2'b01,
        TRACK_WEST = 2'b10
    } track_e;

    localparam int unsigned FAULT_CNT_W = 8;
    localparam int unsigned TRACK_W     = 2;

endpackage

// File: rtl/user_proj_solar_mc_if.sv
// -----------------------------------------------------------------------------
// solar_if
// Tagged sample bus from the panel sensor front-end.
//   smp_valid_i : sample strobe, at most one sample per cycle
//   smp_ch_i    : channel tag of the sample
//   smp_data_i  : unsigned sample value
// Modports: master (front-end / bench drives), slave (monitor core receives).
// -----------------------------------------------------------------------------
interface solar_if #(
    parameter int CH = 4,
    parameter int DW = 8
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic           smp_valid_i;
    logic [CHW-1:0] smp_ch_i;
    logic [DW-1:0]  smp_data_i;

    modport master (
        output smp_valid_i,
        output smp_ch_i,
        output smp_data_i
    );

    modport slave (
        input smp_valid_i,
        input smp_ch_i,
        input smp_data_i
    );
endinterface

// File: rtl/solar_chan_avg.sv
// -----------------------------------------------------------------------------
// solar_chan_avg
// One sensor channel: block averager over 2^AVG_LOG2 samples plus a debounced
// under-threshold fault.
//   clk, rst_n  : clock, asynchronous active-low reset
//   smp_en      : an accepted sample for this channel is present this cycle
//   smp_data    : sample value
//   thresh      : fault threshold, only looked at in a window-completing cycle
//   avg         : latest completed window average (registered)
//   avg_valid   : sticky, set once the first window completes
//   fault       : set when FAULT_HOLD consecutive windows averaged below thresh
// -----------------------------------------------------------------------------
module solar_chan_avg
    import solar_pkg::*;
#(
    parameter int DW         = 8,
    parameter int AVG_LOG2   = 3,
    parameter int FAULT_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          smp_en,
    input  logic [DW-1:0] smp_data,
    input  logic [DW-1:0] thresh,
    output logic [DW-1:0] avg,
    output logic          avg_valid,
    output logic          fault
);
    // DW+AVG_LOG2 bits hold 2^AVG_LOG2 full-scale samples, so no overflow.
    localparam int AW = DW + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0]    CNT_LAST = {AVG_LOG2{1'b1}};
    localparam logic [FAULT_CNT_W-1:0] HOLD_L   = FAULT_CNT_W'(FAULT_HOLD);

    logic [AW-1:0]          acc_r;
    logic [AVG_LOG2-1:0]    cnt_r;
    logic [DW-1:0]          avg_r;
    logic                   valid_r;
    logic [FAULT_CNT_W-1:0] fcnt_r;
    logic                   fault_r;

    logic [AW-1:0]          sum_s;
    logic [DW-1:0]          avg_next_s;
    logic                   last_s;
    logic [FAULT_CNT_W-1:0] fcnt_next_s;

    // Window sum including the current sample, truncated average, and the
    // fault counter value that a completing window would produce.
    always_comb begin
        sum_s       = acc_r + {{AVG_LOG2{1'b0}}, smp_data};
        avg_next_s  = sum_s[AW-1:AVG_LOG2];
        last_s      = (cnt_r == CNT_LAST);
        fcnt_next_s = {FAULT_CNT_W{1'b0}};
        if (avg_next_s < thresh) begin
            if (fcnt_r >= HOLD_L) begin
                fcnt_next_s = HOLD_L;
            end else begin
                fcnt_next_s = fcnt_r + FAULT_CNT_W'(1);
            end
        end else begin
            fcnt_next_s = {FAULT_CNT_W{1'b0}};
        end
    end

    // Accumulate samples; on the last sample of a window publish the average,
    // update the fault debounce and restart the window in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {AW{1'b0}};
            cnt_r   <= {AVG_LOG2{1'b0}};
            avg_r   <= {DW{1'b0}};
            valid_r <= 1'b0;
            fcnt_r  <= {FAULT_CNT_W{1'b0}};
            fault_r <= 1'b0;
        end else if (smp_en) begin
            if (last_s) begin
                acc_r   <= {AW{1'b0}};
                cnt_r   <= {AVG_LOG2{1'b0}};
                avg_r   <= avg_next_s;
                valid_r <= 1'b1;
                fcnt_r  <= fcnt_next_s;
                fault_r <= (fcnt_next_s == HOLD_L);
            end else begin
                acc_r <= sum_s;
                cnt_r <= cnt_r + AVG_LOG2'(1);
            end
        end
    end

    assign avg       = avg_r;
    assign avg_valid = valid_r;
    assign fault     = fault_r;

endmodule

// File: rtl/user_proj_solar_mc.sv
// -----------------------------------------------------------------------------
// user_proj_solar_mc
// Multi-channel solar monitor: per-channel block averages, debounced
// under-threshold faults with a global alarm, and east/west sun tracking.
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   smp (solar_if.slave): tagged sample bus; tags >= CH are ignored
//   thresh_i            : fault threshold (quasi-static)
//   avg_o               : channel n average at [n*DW +: DW]
//   avg_valid_o         : per-channel sticky "window completed"
//   fault_o             : per-channel debounced fault
//   alarm_o             : registered OR of fault_o
//   track_dir_o         : 00 hold, 01 east, 10 west
// Build option: define SOLAR_TRACK_EN to include the tracking FSM; otherwise
// track_dir_o is tied to 2'b00.
// Channel 0 is the east sensor, channel CH-1 the west sensor.
// -----------------------------------------------------------------------------
module user_proj_solar_mc
    import solar_pkg::*;
#(
    parameter int CH         = 4,
    parameter int DW         = 8,
    parameter int AVG_LOG2   = 3,
    parameter int FAULT_HOLD = 4,
    parameter int HYST       = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    solar_if.slave              smp,
    input  logic [DW-1:0]       thresh_i,
    output logic [CH*DW-1:0]    avg_o,
    output logic [CH-1:0]       avg_valid_o,
    output logic [CH-1:0]       fault_o,
    output logic                alarm_o,
    output logic [TRACK_W-1:0]  track_dir_o
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    // One extra bit so CH itself (e.g. 16 with a 4-bit tag) is representable.
    localparam logic [CHW:0] CH_L = (CHW + 1)'(CH);

    logic smp_ok_s;
    logic alarm_r;

    assign smp_ok_s = smp.smp_valid_i && ({1'b0, smp.smp_ch_i} < CH_L);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        logic sel_s;
        assign sel_s = smp_ok_s && (smp.smp_ch_i == CHW'(g));

        solar_chan_avg #(
            .DW         (DW),
            .AVG_LOG2   (AVG_LOG2),
            .FAULT_HOLD (FAULT_HOLD)
        ) u_chan (
            .clk       (wb_clk_i),
            .rst_n     (wb_rst_ni),
            .smp_en    (sel_s),
            .smp_data  (smp.smp_data_i),
            .thresh    (thresh_i),
            .avg       (avg_o[g*DW +: DW]),
            .avg_valid (avg_valid_o[g]),
            .fault     (fault_o[g])
        );
    end

    // Global alarm, one cycle behind the per-channel fault flags.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            alarm_r <= 1'b0;
        end else begin
            alarm_r <= |fault_o;
        end
    end

    assign alarm_o = alarm_r;

`ifdef SOLAR_TRACK_EN
    localparam logic [DW:0] HYST_L = (DW + 1)'(HYST);

    track_e      track_r;
    track_e      track_next_s;
    logic [DW:0] east_s;
    logic [DW:0] west_s;
    logic        track_en_s;

    // Tracking next state from the registered east/west averages; compares
    // are done one bit wider so adding the hysteresis cannot wrap.
    always_comb begin
        east_s       = {1'b0, avg_o[0 +: DW]};
        west_s       = {1'b0, avg_o[(CH-1)*DW +: DW]};
        track_en_s   = avg_valid_o[0] && avg_valid_o[CH-1];
        track_next_s = track_r;
        if (!track_en_s) begin
            track_next_s = TRACK_HOLD;
        end else begin
            case (track_r)
                TRACK_HOLD: begin
                    if (east_s > west_s + HYST_L) begin
                        track_next_s = TRACK_EAST;
                    end else if (west_s > east_s + HYST_L) begin
                        track_next_s = TRACK_WEST;
                    end else begin
                        track_next_s = TRACK_HOLD;
                    end
                end
                TRACK_EAST: begin
                    if (east_s <= west_s) begin
                        track_next_s = TRACK_HOLD;
                    end else begin
                        track_next_s = TRACK_EAST;
                    end
                end
                TRACK_WEST: begin
                    if (west_s <= east_s) begin
                        track_next_s = TRACK_HOLD;
                    end else begin
                        track_next_s = TRACK_WEST;
                    end
                end
                default: begin
                    track_next_s = TRACK_HOLD;
                end
            endcase
        end
    end

    // Tracking state register; the state encoding is the output encoding.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            track_r <= TRACK_HOLD;
        end else begin
            track_r <= track_next_s;
        end
    end

    assign track_dir_o = track_r;
`else
    assign track_dir_o = 2'b00;
`endif

endmodule

// File: tb/tb_user_proj_solar_mc.sv
module tb_user_proj_solar_mc;
    localparam int CH  = 4;
    localparam int DW  = 8;
    localparam int AL  = 3;
    localparam int WIN = 8;
    localparam int FH  = 4;
    localparam int HY  = 4;
    localparam int CHW = 2;
`ifdef SOLAR_TRACK_EN
    localparam bit TRACK_ON = 1'b1;
`else
    localparam bit TRACK_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [DW-1:0]     thresh;
    logic [CH*DW-1:0]  avg_o;
    logic [CH-1:0]     avg_valid_o;
    logic [CH-1:0]     fault_o;
    logic              alarm_o;
    logic [1:0]        track_dir_o;

    int n_pass;
    int n_total;

    // Reference model state (what the outputs should show after each edge)
    int       m_sum   [CH];
    int       m_cnt   [CH];
    int       m_avg   [CH];
    bit       m_valid [CH];
    int       m_fc    [CH];
    bit       m_alarm;
    int       m_track;   // 0 hold, 1 east, 2 west

    solar_if #(.CH(CH), .DW(DW)) sif ();

    user_proj_solar_mc #(
        .CH(CH), .DW(DW), .AVG_LOG2(AL), .FAULT_HOLD(FH), .HYST(HY)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .smp         (sif.slave),
        .thresh_i    (thresh),
        .avg_o       (avg_o),
        .avg_valid_o (avg_valid_o),
        .fault_o     (fault_o),
        .alarm_o     (alarm_o),
        .track_dir_o (track_dir_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH*DW-1:0] exp_avg();
        logic [CH*DW-1:0] r;
        for (int i = 0; i < CH; i++) r[i*DW +: DW] = DW'(m_avg[i]);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_valid();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = m_valid[i];
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_fault();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = (m_fc[i] == FH);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_avg[i] = 0; m_valid[i] = 0; m_fc[i] = 0;
        end
        m_alarm = 0;
        m_track = 0;
    endtask

    // One clock: present inputs at a falling edge, let the rising edge take
    // them, then advance the model to the state visible at the next falling edge.
    task automatic cycle(input bit v, input int ch, input int d);
        bit na;
        int nt;
        int e;
        int w;
        sif.smp_valid_i = v;
        sif.smp_ch_i    = CHW'(ch);
        sif.smp_data_i  = DW'(d);
        @(negedge clk);
        na = 0;
        for (int i = 0; i < CH; i++) if (m_fc[i] == FH) na = 1;
        e  = m_avg[0];
        w  = m_avg[CH-1];
        nt = m_track;
        if (!TRACK_ON || !(m_valid[0] && m_valid[CH-1])) nt = 0;
        else if (m_track == 0) nt = (e > w + HY) ? 1 : ((w > e + HY) ? 2 : 0);
        else if (m_track == 1) nt = (e <= w) ? 0 : 1;
        else nt = (w <= e) ? 0 : 2;
        m_alarm = na;
        m_track = nt;
        if (v && ch < CH) begin
            m_sum[ch] += d;
            m_cnt[ch] += 1;
            if (m_cnt[ch] == WIN) begin
                m_avg[ch]   = m_sum[ch] / WIN;
                m_valid[ch] = 1;
                if (m_avg[ch] < int'(thresh)) m_fc[ch] = (m_fc[ch] + 1 > FH) ? FH : m_fc[ch] + 1;
                else m_fc[ch] = 0;
                m_sum[ch] = 0;
                m_cnt[ch] = 0;
            end
        end
    endtask

    task automatic do_reset();
        sif.smp_valid_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        thresh = DW'($urandom);
        model_clear();
        for (int k = 0; k < 4; k++) begin
            sif.smp_valid_i = 1'($urandom);
            sif.smp_ch_i    = CHW'($urandom);
            sif.smp_data_i  = DW'($urandom);
            @(negedge clk);
            n_total++;
            if ({avg_o, avg_valid_o, fault_o, alarm_o, track_dir_o} !== '0)
                $display("FAIL reset_hold: got avg=%h v=%b f=%b a=%b t=%b, want all 0",
                         avg_o, avg_valid_o, fault_o, alarm_o, track_dir_o);
            else n_pass++;
        end
        sif.smp_valid_i = 1'b0;
        rst_n = 1'b1;
        thresh = 8'd0;
        for (int k = 0; k < WIN; k++) cycle(1'b1, 0, 200);
        n_total++;
        if (avg_o[7:0] !== 8'd200 || avg_valid_o !== 4'b0001)
            $display("FAIL reset_prefill: got avg0=%0d v=%b, want 200 0001", avg_o[7:0], avg_valid_o);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({avg_o, avg_valid_o, fault_o, alarm_o, track_dir_o} !== '0)
            $display("FAIL reset_async: got avg=%h v=%b, want 0 before next edge", avg_o, avg_valid_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_average();
        do_reset();
        thresh = 8'd0;
        for (int k = 0; k < WIN; k++) cycle(1'b1, 1, 100);
        n_total++;
        if (avg_o[15:8] !== 8'd100 || avg_valid_o !== 4'b0010)
            $display("FAIL avg_ch1: got %0d v=%b, want 100 0010", avg_o[15:8], avg_valid_o);
        else n_pass++;
        for (int k = 0; k < WIN; k++) cycle(1'b1, 0, 255);
        n_total++;
        if (avg_o[7:0] !== 8'd255)
            $display("FAIL avg_ch0_full: got %0d, want 255", avg_o[7:0]);
        else n_pass++;
        for (int k = 0; k < WIN; k++) cycle(1'b1, 2, k);
        n_total++;
        if (avg_o[23:16] !== 8'd3 || avg_valid_o !== 4'b0111)
            $display("FAIL avg_ch2_trunc: got %0d v=%b, want 3 0111", avg_o[23:16], avg_valid_o);
        else n_pass++;
        n_total++;
        if (avg_o !== exp_avg())
            $display("FAIL avg_model: got %h, want %h", avg_o, exp_avg());
        else n_pass++;
    endtask

    // A window whose truncated average is 'a', with random spread.
    task automatic send_window(input int ch, input int a);
        int s;
        int d;
        s = 0;
        for (int k = 0; k < WIN - 1; k++) begin
            d = a - 5 + int'($urandom_range(0, 10));
            s += d;
            cycle(1'b1, ch, d);
        end
        cycle(1'b1, ch, a * WIN - s + int'($urandom_range(0, WIN - 1)));
    endtask

    task automatic test_fault();
        do_reset();
        thresh = 8'd50;
        for (int w = 0; w < 3; w++) send_window(2, 40);
        n_total++;
        if (fault_o !== 4'b0000)
            $display("FAIL fault_early: got %b, want 0000", fault_o);
        else n_pass++;
        send_window(2, 40);
        n_total++;
        if (fault_o !== 4'b0100 || alarm_o !== 1'b0)
            $display("FAIL fault_set: got f=%b a=%b, want 0100 0", fault_o, alarm_o);
        else n_pass++;
        cycle(1'b0, 0, 0);
        n_total++;
        if (alarm_o !== 1'b1)
            $display("FAIL alarm_set: got %b, want 1", alarm_o);
        else n_pass++;
        send_window(2, 50);
        n_total++;
        if (fault_o[2] !== 1'b0 || avg_o[23:16] !== 8'd50)
            $display("FAIL fault_clear_eq: got f=%b avg=%0d, want 0 50", fault_o[2], avg_o[23:16]);
        else n_pass++;
        send_window(2, 40);
        cycle(1'b0, 0, 0);
        n_total++;
        if (fault_o[2] !== 1'b0 || alarm_o !== 1'b0 || fault_o !== exp_fault())
            $display("FAIL fault_restart: got f=%b a=%b, want 0 0", fault_o[2], alarm_o);
        else n_pass++;
        thresh = 8'd0;
    endtask

    task automatic test_track();
        int seq_ch  [5] = '{0, 0, 0, 3, 3};
        int seq_v   [5] = '{120, 103, 100, 104, 105};
        int seq_exp [5] = '{1, 1, 0, 0, 2};
        logic [1:0] want;
        do_reset();
        thresh = 8'd0;
        send_window(3, 100);
        cycle(1'b0, 0, 0);
        n_total++;
        if (track_dir_o !== 2'b00)
            $display("FAIL track_one_valid: got %b, want 00", track_dir_o);
        else n_pass++;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < WIN; k++) cycle(1'b1, seq_ch[s], seq_v[s]);
            cycle(1'b0, 0, 0);
            cycle(1'b0, 0, 0);
            want = TRACK_ON ? 2'(seq_exp[s]) : 2'b00;
            n_total++;
            if (track_dir_o !== want || track_dir_o !== 2'(m_track))
                $display("FAIL track_step%0d: got %b, want %b", s, track_dir_o, want);
            else n_pass++;
        end
    endtask

    task automatic test_partial_reset();
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 3, 200);
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, 3, 200);
        n_total++;
        if (avg_valid_o[3] !== 1'b0 || avg_o[31:24] !== 8'd0)
            $display("FAIL partial_discard: got v=%b avg=%0d, want 0 0", avg_valid_o[3], avg_o[31:24]);
        else n_pass++;
        for (int k = 0; k < 5; k++) cycle(1'b1, 3, 16);
        n_total++;
        if (avg_valid_o[3] !== 1'b1 || avg_o[31:24] !== 8'd85)
            $display("FAIL partial_complete: got v=%b avg=%0d, want 1 85", avg_valid_o[3], avg_o[31:24]);
        else n_pass++;
        for (int k = 0; k < WIN; k++) cycle(1'b1, 3, 70);
        n_total++;
        if (avg_o[31:24] !== 8'd70)
            $display("FAIL partial_next: got %0d, want 70", avg_o[31:24]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        thresh = DW'($urandom);
        for (int k = 0; k < 4 * WIN; k++) begin
            cycle(1'b1, k % CH, int'($urandom_range(0, 255)));
            n_total++;
            if (avg_o !== exp_avg() || avg_valid_o !== exp_valid() || fault_o !== exp_fault())
                $display("FAIL b2b_cyc%0d: got avg=%h v=%b f=%b, want avg=%h v=%b f=%b",
                         k, avg_o, avg_valid_o, fault_o, exp_avg(), exp_valid(), exp_fault());
            else n_pass++;
        end
        n_total++;
        if (avg_valid_o !== 4'b1111)
            $display("FAIL b2b_all_valid: got %b, want 1111", avg_valid_o);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 63) == 0) thresh = DW'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, CH - 1)),
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(90, 130)));
            n_total++;
            if (avg_o !== exp_avg() || avg_valid_o !== exp_valid() || fault_o !== exp_fault() ||
                alarm_o !== m_alarm || track_dir_o !== 2'(m_track))
                $display("FAIL rand_cyc%0d: got avg=%h v=%b f=%b a=%b t=%b, want avg=%h v=%b f=%b a=%b t=%0d",
                         k, avg_o, avg_valid_o, fault_o, alarm_o, track_dir_o,
                         exp_avg(), exp_valid(), exp_fault(), m_alarm, m_track);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        thresh  = 8'd0;
        sif.smp_valid_i = 1'b0;
        sif.smp_ch_i    = '0;
        sif.smp_data_i  = '0;
        @(negedge clk);
        test_reset();
        test_average();
        test_fault();
        test_track();
        test_partial_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/user_proj_solar_mc.md
# user_proj_solar_mc

Parametrised multi-channel successor to the single-channel solar monitor core inside the Caravel user project wrapper. Accepts tagged light/voltage samples from the panel sensor front-end, computes a per-channel block average, debounces per-channel under-threshold faults into an alarm, and drives an east/west sun-tracking direction with hysteresis. Sits directly under `user_project_wrapper`; all ports map to `io_in`/`io_out`/`io_oeb` slices there.

## Interface
- `CH`, 4: number of sensor channels (2..16); channel 0 = east sensor, channel `CH-1` = west sensor.
- `DW`, 8: sample and average width.
- `AVG_LOG2`, 3: window length is 2^`AVG_LOG2` samples per channel.
- `FAULT_HOLD`, 4: consecutive low windows before a channel faults (1..255).
- `HYST`, 4: tracking hysteresis, in LSBs.

- `wb_clk_i`  in  1  single clock.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `smp_valid_i`  in  1  sample strobe, one sample per cycle max.
- `smp_ch_i`  in  $clog2(CH)  channel tag of the sample.
- `smp_data_i`  in  DW  unsigned sample.
- `thresh_i`  in  DW  fault threshold, quasi-static.
- `avg_o`  out  CH*DW  per-channel latest average, channel n at [n*DW +: DW].
- `avg_valid_o`  out  CH  sticky: channel has completed at least one window.
- `fault_o`  out  CH  per-channel debounced fault.
- `alarm_o`  out  1  registered OR of `fault_o`.
- `track_dir_o`  out  2  00 hold, 01 east, 10 west.

## Operation
- Reset (async assert, sync release by the wrapper): all accumulators, counters, state cleared; every output 0; tracking state HOLD.
- Per channel: accumulator width `DW+AVG_LOG2` (cannot overflow), sample counter `AVG_LOG2` bits.
- Sample accepted when `smp_valid_i`=1 and `smp_ch_i` < `CH`; tags ≥ `CH` ignored, no state change.
- On the 2^`AVG_LOG2`-th sample of a window: avg = (acc + sample) >> `AVG_LOG2` (truncating); acc and count reset to 0 in that same edge; `avg_valid_o[n]` set.
- Fault counter per channel, evaluated at each window completion: avg < `thresh_i` → saturating increment to `FAULT_HOLD`; otherwise clear to 0. `fault_o[n]` = (counter == `FAULT_HOLD`). Equality (avg == thresh) is not low.
- Tracking FSM, evaluated every cycle on registered averages, only while `avg_valid_o[0]` and `avg_valid_o[CH-1]` are both 1 (else forced HOLD):
  - HOLD → EAST if E > W + `HYST`; HOLD → WEST if W > E + `HYST`.
  - EAST → HOLD if E ≤ W; WEST → HOLD if W ≤ E. No direct EAST↔WEST transition.
  - Comparisons in `DW+1` bits; no wrap.

## Timing
- Completing sample at edge t: `avg_o`, `avg_valid_o`, `fault_o` update at t+1.
- `alarm_o` and `track_dir_o` follow at t+2.
- `thresh_i` sampled only in the completing cycle.
- Reset mid-window discards the partial window entirely.

## Configuration
- `SOLAR_TRACK_EN`: defined → tracking FSM present as above. Undefined → FSM not built, `track_dir_o` tied 2'b00; averaging and fault logic unchanged.

## Structure
- Package `solar_pkg`: track state enum (`TRACK_HOLD`=2'b00, `TRACK_EAST`=2'b01, `TRACK_WEST`=2'b10) and shared width constants.
- Sub-module `solar_chan_avg`: one per channel via generate; holds accumulator, window counter, average register, valid bit, fault counter. Tracking FSM and alarm register live in the top.

## Test plan
Defaults: CH=4, DW=8, AVG_LOG2=3, FAULT_HOLD=4, HYST=4.
- Reset: hold `wb_rst_ni`=0 with random inputs → all outputs 0; assert reset asynchronously mid-cycle → outputs 0 before next edge.
- Eight samples of 100 on ch1 → one cycle after 8th: `avg_o[15:8]`=100, `avg_valid_o`=4'b0010; 8×255 on ch0 → 255 (no overflow); values 0..7 on ch2 → avg 3 (truncation).
- `thresh_i`=50, four ch2 windows averaging 40 → `fault_o[2]`=1 after 4th window, `alarm_o` one cycle later; one window averaging 50 → `fault_o[2]`=0, counter restarts.
- Tracking: E=120,W=100 → 01; E=103,W=100 → stays 01; E=100,W=100 → 00; W=104 → 00; W=105 → 10. With `SOLAR_TRACK_EN` undefined → 00 throughout.
- 5 samples on ch3, reset, 3 more samples → no window completion, `avg_valid_o[3]`=0; then 8 samples → completes normally.
- Interleaved back-to-back samples across all four channels, 32 cycles → each channel completes exactly one window, averages match per-channel model.
